hyperram_bus_arbiter: RTL and testbench

HYPERRAM_BUS_ARBITER -- requirements
Module: hyperram_bus_arbiter

---
 rtl/hyperram_bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_hyperram_bus_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_bus_arbiter.sv
// Arbitrates the shared HyperRAM between the IR FPGA (writer) and the local burst
// reader, with guard windows at every hand-over, a CE-low watchdog and retry handling.
module hyperram_bus_arbiter #(
    parameter int unsigned GUARD_CYC      = 8,
    parameter int unsigned CE_MAX_CYC     = 96,
    parameter int unsigned BURST_BYTES    = 12,
    parameter int unsigned FRAME_BYTES    = 1032,
    parameter int unsigned WR_TIMEOUT_CYC = 576000000,
    parameter int unsigned MAX_RETRY      = 10
) (
    input  logic        clk_48MHz,
    input  logic        rst_n,
    input  logic        wr_req_i,
    input  logic        wr_done_i,
    output logic        owner_o,
    output logic        rd_start_o,
    output logic [31:0] rd_addr_o,
    input  logic        rd_done_i,
    input  logic        rd_ok_i,
    input  logic        ce_local_i,
    output logic        ce_abort_o,
    output logic        frame_done_o,
    output logic        busy_o,
    output logic [1:0]  err_o,
    output logic [2:0]  state_o
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        IR_OWN    = 3'd1,
        GUARD_LOC = 3'd2,
        RD_ISSUE  = 3'd3,
        RD_WAIT   = 3'd4,
        GUARD_IR  = 3'd5
    } state_t;

    localparam int GW = $clog2(GUARD_CYC + 1);
    localparam int CW = $clog2(CE_MAX_CYC + 1);
    localparam int TW = $clog2(WR_TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
    localparam logic [CW-1:0] CE_LAST    = CW'(CE_MAX_CYC - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(WR_TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
    localparam logic [31:0]   BURST_STEP = 32'(BURST_BYTES);
    localparam logic [31:0]   FRAME_LIM  = 32'(FRAME_BYTES);

    state_t        state;
    logic          owner, rdStart, ceAbort, frameDone, pending, aborted;
    logic [31:0]   rdAddr;
    logic [1:0]    err;
    logic [GW-1:0] guardCnt;
    logic [CW-1:0] ceCnt;
    logic [TW-1:0] wrTimer;
    logic [RW-1:0] retryCnt;
    logic [2:0]    reqSync, doneSync;

    logic        reqEdge, doneEdge, abortNow, burstFailed, retryExhausted, advance, pendingNow;
    logic [31:0] nextAddr;

    // Two flops resolve metastability, the third holds the previous level for edge detection.
    always_ff @(posedge clk_48MHz or negedge rst_n) begin
        if (!rst_n) begin
            reqSync  <= '0;
            doneSync <= '0;
        end else begin
            reqSync  <= {reqSync[1:0], wr_req_i};
            doneSync <= {doneSync[1:0], wr_done_i};
        end
    end

    always_comb begin
        reqEdge        = reqSync[1] & ~reqSync[2];
        doneEdge       = doneSync[1] & ~doneSync[2];
        nextAddr       = rdAddr + BURST_STEP;
        abortNow       = (state == RD_WAIT) && !ce_local_i && !aborted && (ceCnt == CE_LAST);
        burstFailed    = !rd_ok_i || aborted || abortNow;
        retryExhausted = (retryCnt == RETRY_LAST);
        advance        = !burstFailed || retryExhausted;
        pendingNow     = pending || reqEdge;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_48MHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            rdStart   <= 1'b0;
            rdAddr    <= '0;
            ceAbort   <= 1'b0;
            frameDone <= 1'b0;
            err       <= '0;
            pending   <= 1'b0;
            aborted   <= 1'b0;
            guardCnt  <= '0;
            ceCnt     <= '0;
            wrTimer   <= '0;
            retryCnt  <= '0;
        end else begin
            rdStart   <= 1'b0;
            ceAbort   <= 1'b0;
            frameDone <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (reqEdge) begin
                        state   <= IR_OWN;
                        wrTimer <= '0;
                    end
                end
                IR_OWN: begin
                    if (doneEdge || wrTimer == TIMER_LAST) begin
                        if (!doneEdge) err[0] <= 1'b1;
                        state    <= GUARD_LOC;
                        guardCnt <= '0;
                        rdAddr   <= '0;
                        retryCnt <= '0;
                    end else begin
                        wrTimer <= wrTimer + TW'(1);
                    end
                end
                GUARD_LOC: begin
                    if (reqEdge) pending <= 1'b1;
                    if (guardCnt == GUARD_LAST) begin
                        owner   <= 1'b1;
                        rdStart <= 1'b1;
                        state   <= RD_ISSUE;
                    end else begin
                        guardCnt <= guardCnt + GW'(1);
                    end
                end
                RD_ISSUE: begin
                    if (reqEdge) pending <= 1'b1;
                    ceCnt   <= '0;
                    aborted <= 1'b0;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (reqEdge) pending <= 1'b1;
                    // The watchdog fires once per burst; the reader still owes us rd_done_i.
                    if (!ce_local_i) begin
                        if (abortNow) begin
                            ceAbort <= 1'b1;
                            aborted <= 1'b1;
                        end else if (ceCnt != CE_LAST) begin
                            ceCnt <= ceCnt + CW'(1);
                        end
                    end else begin
                        ceCnt <= '0;
                    end
                    if (rd_done_i) begin
                        retryCnt <= advance ? '0 : retryCnt + RW'(1);
                        if (burstFailed && retryExhausted) err[1] <= 1'b1;
                        if (pendingNow) begin
                            state    <= GUARD_IR;
                            guardCnt <= '0;
                        end else if (advance && nextAddr >= FRAME_LIM) begin
                            frameDone <= 1'b1;
                            state     <= GUARD_IR;
                            guardCnt  <= '0;
                        end else begin
                            if (advance) rdAddr <= nextAddr;
                            rdStart <= 1'b1;
                            state   <= RD_ISSUE;
                        end
                    end
                end
                GUARD_IR: begin
                    // A request arriving during the hand-back is kept rather than dropped.
                    if (reqEdge) pending <= 1'b1;
                    if (guardCnt == GUARD_LAST) begin
                        owner <= 1'b0;
                        if (pendingNow) begin
                            pending <= 1'b0;
                            wrTimer <= '0;
                            state   <= IR_OWN;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        guardCnt <= guardCnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign owner_o      = owner;
    assign rd_start_o   = rdStart;
    assign rd_addr_o    = rdAddr;
    assign ce_abort_o   = ceAbort;
    assign frame_done_o = frameDone;
    assign err_o        = err;
    assign state_o      = state;
    assign busy_o       = (state != IDLE);
endmodule

// File: tb/tb_hyperram_bus_arbiter.sv
// Scoreboard bench: a reader model answers bursts at random, a frame-level model predicts
// the burst address sequence and frame completions, and a monitor compares DUT events.
module tb_hyperram_bus_arbiter;
    localparam int unsigned GUARD_CYC      = 8;
    localparam int unsigned CE_MAX_CYC     = 96;
    localparam int unsigned BURST_BYTES    = 12;
    localparam int unsigned FRAME_BYTES    = 1032;
    localparam int unsigned WR_TIMEOUT_CYC = 1000;
    localparam int unsigned MAX_RETRY      = 10;

    logic        clk_48MHz = 1'b0;
    logic        rst_n, wr_req_i, wr_done_i, rd_done_i, rd_ok_i, ce_local_i;
    logic        owner_o, rd_start_o, ce_abort_o, frame_done_o, busy_o;
    logic [31:0] rd_addr_o;
    logic [1:0]  err_o;
    logic [2:0]  state_o;

    always #10 clk_48MHz = ~clk_48MHz;

    hyperram_bus_arbiter #(
        .GUARD_CYC(GUARD_CYC), .CE_MAX_CYC(CE_MAX_CYC), .BURST_BYTES(BURST_BYTES),
        .FRAME_BYTES(FRAME_BYTES), .WR_TIMEOUT_CYC(WR_TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk_48MHz(clk_48MHz), .rst_n(rst_n), .wr_req_i(wr_req_i), .wr_done_i(wr_done_i),
        .owner_o(owner_o), .rd_start_o(rd_start_o), .rd_addr_o(rd_addr_o),
        .rd_done_i(rd_done_i), .rd_ok_i(rd_ok_i), .ce_local_i(ce_local_i),
        .ce_abort_o(ce_abort_o), .frame_done_o(frame_done_o), .busy_o(busy_o),
        .err_o(err_o), .state_o(state_o)
    );

    typedef enum {EV_START, EV_FRAME} ev_kind_t;
    typedef struct { ev_kind_t kind; logic [31:0] addr; } ev_t;
    ev_t expQ[$];

    int checks = 0, failures = 0;
    int startsSeen = 0, framesSeen = 0, abortsSeen = 0, addr24Starts = 0;
    bit          modelActive = 0, modelPending = 0;
    int          modelRetry = 0;
    logic [1:0]  expErr = '0;
    logic [31:0] failAddr = '1, abortAddr = '1;
    int          failPct = 0, minDelay = 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] actual);
        checks++;
        failures++;
        $display("FAIL %s: unexpected event, value 0x%0h", name, actual);
    endtask

    // Frame-level reference: retries per burst, skip after MAX_RETRY, stop at frame end or on request.
    task automatic start_session();
        modelActive  = 1;
        modelPending = 0;
        modelRetry   = 0;
        expQ.push_back('{EV_START, 32'd0});
    endtask

    task automatic model_complete(input logic [31:0] addr, input bit failed);
        logic [31:0] nxt;
        bit          adv;
        if (!modelActive) return;
        adv = 1;
        if (failed) begin
            modelRetry++;
            adv = (modelRetry == MAX_RETRY);
            if (adv) begin
                expErr[1]  = 1'b1;
                modelRetry = 0;
            end
        end else begin
            modelRetry = 0;
        end
        nxt = adv ? addr + BURST_BYTES : addr;
        if (modelPending) begin
            modelPending = 0;
            modelActive  = 0;
        end else if (nxt >= FRAME_BYTES) begin
            expQ.push_back('{EV_FRAME, nxt});
            modelActive = 0;
        end else begin
            expQ.push_back('{EV_START, nxt});
        end
    endtask

    // Reader model: CE low for the burst, random latency, random or forced failures.
    initial begin : reader
        logic [31:0] addr;
        bit          ok, failed, abortUsed;
        int          lowCnt;
        abortUsed  = 0;
        rd_done_i  = 1'b0;
        rd_ok_i    = 1'b0;
        ce_local_i = 1'b1;
        forever begin
            @(negedge clk_48MHz);
            if (rst_n && rd_start_o) begin
                addr       = rd_addr_o;
                ce_local_i = 1'b0;
                if (addr == abortAddr && !abortUsed) begin
                    abortUsed = 1;
                    lowCnt    = 0;
                    for (int i = 0; i < 300; i++) begin
                        @(negedge clk_48MHz);
                        if (ce_abort_o) break;
                        if (state_o == 3'd4) lowCnt++;
                    end
                    check("ce_abort_cycle", lowCnt, CE_MAX_CYC);
                    repeat (20) @(negedge clk_48MHz);
                    ok     = 1;
                    failed = 1;
                end else begin
                    ok     = (addr != failAddr) && ($urandom_range(99, 0) >= failPct);
                    failed = !ok;
                    repeat (minDelay + $urandom_range(4, 0)) @(negedge clk_48MHz);
                end
                ce_local_i = 1'b1;
                model_complete(addr, failed);
                rd_ok_i   = ok;
                rd_done_i = 1'b1;
                @(posedge clk_48MHz);
                #1;
                rd_done_i = 1'b0;
                rd_ok_i   = 1'b0;
            end
        end
    end

    initial begin : monitor
        ev_t        ev;
        logic [2:0] prevState;
        int         runLen;
        prevState = 3'd0;
        runLen    = 0;
        forever begin
            @(negedge clk_48MHz);
            if (!rst_n) begin
                prevState = 3'd0;
                runLen    = 0;
            end else begin
                if (state_o != prevState) begin
                    if (prevState == 3'd2) check("guard_loc_len", runLen, GUARD_CYC);
                    if (prevState == 3'd5) check("guard_ir_len", runLen, GUARD_CYC);
                    runLen = 0;
                end
                runLen++;
                prevState = state_o;
                if (state_o == 3'd2) check("guard_loc_owner", owner_o, 1'b0);
                if (state_o == 3'd5) check("guard_ir_owner", owner_o, 1'b1);
                if (rd_start_o) begin
                    startsSeen++;
                    if (rd_addr_o == 32'd24) addr24Starts++;
                    check("start_owner", owner_o, 1'b1);
                    if (expQ.size() == 0) fail("start_unexpected", rd_addr_o);
                    else begin
                        ev = expQ.pop_front();
                        if (ev.kind != EV_START) fail("start_instead_of_frame_done", rd_addr_o);
                        else check("start_addr", rd_addr_o, ev.addr);
                    end
                end
                if (frame_done_o) begin
                    framesSeen++;
                    if (expQ.size() == 0) fail("frame_done_unexpected", rd_addr_o);
                    else begin
                        ev = expQ.pop_front();
                        if (ev.kind != EV_FRAME) fail("frame_done_early", ev.addr);
                        else check("frame_done_addr", rd_addr_o + BURST_BYTES, ev.addr);
                    end
                end
                if (ce_abort_o) abortsSeen++;
            end
        end
    end

    task automatic pulse_req();
        wr_req_i = 1'b1;
        repeat (6) @(negedge clk_48MHz);
        wr_req_i = 1'b0;
    endtask

    task automatic pulse_done();
        wr_done_i = 1'b1;
        repeat (6) @(negedge clk_48MHz);
        wr_done_i = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        int n = 0;
        while (state_o !== target && n < budget) begin
            @(negedge clk_48MHz);
            n++;
        end
        check(name, state_o, target);
    endtask

    task automatic wait_start(input logic [31:0] addr, input int budget, input string name);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk_48MHz);
            found = rd_start_o && (rd_addr_o == addr);
        end
        check(name, found, 1'b1);
    endtask

    task automatic run_to_idle(input string name);
        wait_state(3'd0, 20000, name);
        check({name, "_queue_empty"}, expQ.size(), 0);
        check({name, "_owner"}, owner_o, 1'b0);
        check({name, "_err"}, err_o, expErr);
    endtask

    initial begin : main
        int startBase, frameBase, irCycles;
        rst_n     = 1'b0;
        wr_req_i  = 1'b0;
        wr_done_i = 1'b0;
        repeat (3) @(negedge clk_48MHz);
        check("rst_owner", owner_o, 1'b0);
        check("rst_state", state_o, 3'd0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 2'b00);
        check("rst_rd_start", rd_start_o, 1'b0);
        check("rst_rd_addr", rd_addr_o, 32'd0);
        check("rst_ce_abort", ce_abort_o, 1'b0);
        check("rst_frame_done", frame_done_o, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_48MHz);

        // A lone write-done in IDLE is ignored.
        pulse_done();
        repeat (6) @(negedge clk_48MHz);
        check("idle_ignores_done", state_o, 3'd0);

        // Full frame with an always-good reader.
        startBase = startsSeen; frameBase = framesSeen;
        pulse_req();
        wait_state(3'd1, 20, "enter_ir_own");
        check("ir_own_owner", owner_o, 1'b0);
        check("ir_own_busy", busy_o, 1'b1);
        repeat (94) @(negedge clk_48MHz);
        start_session();
        pulse_done();
        run_to_idle("frame_ok");
        check("frame_ok_starts", startsSeen - startBase, 86);
        check("frame_ok_frames", framesSeen - frameBase, 1);

        // Address 24 always fails, plus sporadic random failures elsewhere.
        failAddr = 32'd24; failPct = 10; addr24Starts = 0; frameBase = framesSeen;
        pulse_req();
        wait_state(3'd1, 20, "retry_ir_own");
        start_session();
        pulse_done();
        run_to_idle("frame_retry");
        check("retry_attempts_at_24", addr24Starts, MAX_RETRY);
        check("retry_err_skip", err_o[1], 1'b1);
        check("retry_frames", framesSeen - frameBase, 1);

        // CE held low too long on the burst at 48: one abort, the burst is reissued.
        failAddr = '1; failPct = 0; abortAddr = 32'd48;
        startBase = startsSeen; frameBase = framesSeen;
        pulse_req();
        wait_state(3'd1, 20, "abort_ir_own");
        start_session();
        pulse_done();
        run_to_idle("frame_abort");
        check("abort_pulses", abortsSeen, 1);
        check("abort_starts", startsSeen - startBase, 87);
        check("abort_frames", framesSeen - frameBase, 1);
        abortAddr = '1;

        // A new write request during the burst at 60 ends the session after that burst.
        minDelay = 14; frameBase = framesSeen;
        pulse_req();
        wait_state(3'd1, 20, "preempt_ir_own");
        start_session();
        pulse_done();
        wait_start(32'd60, 2000, "preempt_saw_60");
        modelPending = 1;
        pulse_req();
        wait_state(3'd5, 100, "preempt_guard_ir");
        wait_state(3'd1, 50, "preempt_back_to_ir");
        check("preempt_no_frame_done", framesSeen - frameBase, 0);
        check("preempt_queue_empty", expQ.size(), 0);
        check("preempt_owner", owner_o, 1'b0);
        minDelay = 1;
        start_session();
        pulse_done();
        run_to_idle("frame_after_preempt");
        check("preempt_total_frames", framesSeen - frameBase, 1);

        // No write-done: the timeout flags err_o[0] and reading starts anyway.
        start_session();
        expErr[0] = 1'b1;
        irCycles  = 0;
        wr_req_i  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_48MHz);
            if (i == 5) wr_req_i = 1'b0;
            if (state_o == 3'd1) irCycles++;
            else if (irCycles > 0) break;
        end
        check("timeout_len", irCycles, WR_TIMEOUT_CYC);
        check("timeout_state", state_o, 3'd2);
        check("timeout_err", err_o, expErr);
        run_to_idle("frame_timeout");

        // Simultaneous request and done edges from IDLE: request wins, done is not remembered.
        wr_req_i = 1'b1; wr_done_i = 1'b1;
        repeat (6) @(negedge clk_48MHz);
        wr_req_i = 1'b0; wr_done_i = 1'b0;
        repeat (20) @(negedge clk_48MHz);
        check("simultaneous_stays_ir", state_o, 3'd1);

        // Asynchronous reset while the reader owns the bus.
        start_session();
        pulse_done();
        wait_start(32'd24, 500, "reset_saw_24");
        repeat (3) @(negedge clk_48MHz);
        check("reset_pre_owner", owner_o, 1'b1);
        modelActive = 0;
        expQ.delete();
        expErr = '0;
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_owner_now", owner_o, 1'b0);
        check("reset_err_now", err_o, 2'b00);
        check("reset_state_now", state_o, 3'd0);
        check("reset_busy_now", busy_o, 1'b0);
        repeat (3) @(negedge clk_48MHz);
        rst_n = 1'b1;
        startBase = startsSeen;
        repeat (30) @(negedge clk_48MHz);
        check("post_reset_idle", state_o, 3'd0);
        check("post_reset_no_start", startsSeen - startBase, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end
endmodule
